// File: rtl/touch_evt_pkg.sv
// Shared definitions for the touch event queue.
// Holds the event type codes, the Avalon register map, the CTRL bit indices,
// the gesture FSM states, and helpers that build event words and compute
// coordinate distances.
package touch_evt_pkg;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_MOVE    = 2'b10,
        EVT_RELEASE = 2'b11
    } evt_type_t;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_EVENT  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_THR    = 2'd3;

    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_OVF_CLR = 1;
    localparam int unsigned CTRL_FLUSH   = 2;

    typedef enum logic {
        ST_IDLE,
        ST_PRESSED
    } fsm_state_t;

    function automatic logic [31:0] evt_word(input evt_type_t t,
                                             input logic [11:0] x,
                                             input logic [11:0] y);
        return {t, 2'b00, x, 4'h0, y};
    endfunction

    function automatic logic [11:0] abs_diff(input logic [11:0] a,
                                             input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/touch_event_queue_if.sv
// Avalon-MM slave bus and interrupt line of the touch event queue.
// Signals:
//   avl_address   - register select
//   avl_write     - write strobe
//   avl_writedata - write data
//   avl_read      - read strobe
//   avl_readdata  - registered read data, 1-cycle latency
//   irq           - level interrupt
// The master modport belongs to the CPU side and the slave modport to the queue.
interface touch_event_queue_if;
    logic [1:0]  avl_address;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic        avl_read;
    logic [31:0] avl_readdata;
    logic        irq;

    modport master (
        output avl_address, avl_write, avl_writedata, avl_read,
        input  avl_readdata, irq
    );

    modport slave (
        input  avl_address, avl_write, avl_writedata, avl_read,
        output avl_readdata, irq
    );
endinterface

// File: rtl/touch_evt_fifo.sv
// Synchronous FIFO for event words.
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   push, wdata       - enqueue request and its data
//   pop               - dequeue request; ignored when empty
//   flush             - empties the FIFO; takes priority over push and pop
//   rdata             - head entry
//   full, empty       - occupancy flags
//   count             - number of stored entries (AW+1 bits)
// A push is accepted while full when a pop happens in the same cycle.
module touch_evt_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned W  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW + 1)'(DEPTH));
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/touch_event_queue.sv
// Touch event queue.
// Turns the touch controller's sample stream into PRESS / MOVE / RELEASE
// events, queues them, and exposes them to software over Avalon-MM.
// Ports:
//   sys_clk, sys_rst_n - clock and asynchronous active-low reset
//   touch_done         - one-cycle pulse, new sample on tp_xy
//   touch_valid        - level, panel currently touched
//   tp_xy              - x in [27:16], y in [11:0]
//   avl                - Avalon-MM slave bus plus irq (touch_event_queue_if.slave)
module touch_event_queue
    import touch_evt_pkg::*;
#(
    parameter int unsigned FIFO_AW      = 4,
    parameter logic [23:0] RELEASE_TO   = 24'd5_000_000,
    parameter logic [7:0]  MOVE_THR_RST = 8'd4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 touch_done,
    input  logic                 touch_valid,
    input  logic [31:0]          tp_xy,
    touch_event_queue_if.slave   avl
);
    fsm_state_t   state_q, state_d;
    logic [11:0]  last_x_q, last_x_d, last_y_q, last_y_d;
    logic [23:0]  cnt_q, cnt_d;
    logic         evt_push;
    logic [31:0]  evt_data;

    logic         fifo_pop, fifo_flush, full, empty;
    logic [FIFO_AW:0] count;
    logic [31:0]  head;

    logic         overflow, irq_en, irq_q;
    logic [7:0]   move_thr;
    logic [31:0]  readdata_q;
    logic         wr_ctrl, wr_thr;

    logic [11:0]  smp_x, smp_y;
    logic         unused_bits;

    assign smp_x       = tp_xy[27:16];
    assign smp_y       = tp_xy[11:0];
    assign unused_bits = ^{tp_xy[31:28], tp_xy[15:12], avl.avl_writedata[31:8]};

    // Gesture FSM: loss of touch_valid outranks a new sample, which outranks the timeout.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            last_x_q <= '0;
            last_y_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_x_q <= last_x_d;
            last_y_q <= last_y_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_x_d = last_x_q;
        last_y_d = last_y_q;
        cnt_d    = cnt_q;
        evt_push = 1'b0;
        evt_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (touch_done && touch_valid) begin
                    evt_push = 1'b1;
                    evt_data = evt_word(EVT_PRESS, smp_x, smp_y);
                    last_x_d = smp_x;
                    last_y_d = smp_y;
                    cnt_d    = '0;
                    state_d  = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!touch_valid) begin
                    evt_push = 1'b1;
                    evt_data = evt_word(EVT_RELEASE, last_x_q, last_y_q);
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (touch_done) begin
                    cnt_d = '0;
                    if (abs_diff(smp_x, last_x_q) >= {4'd0, move_thr} ||
                        abs_diff(smp_y, last_y_q) >= {4'd0, move_thr}) begin
                        evt_push = 1'b1;
                        evt_data = evt_word(EVT_MOVE, smp_x, smp_y);
                        last_x_d = smp_x;
                        last_y_d = smp_y;
                    end
                end else if (cnt_q == RELEASE_TO - 24'd1) begin
                    evt_push = 1'b1;
                    evt_data = evt_word(EVT_RELEASE, last_x_q, last_y_q);
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_ctrl    = avl.avl_write && (avl.avl_address == REG_CTRL);
    assign wr_thr     = avl.avl_write && (avl.avl_address == REG_THR);
    assign fifo_flush = wr_ctrl && avl.avl_writedata[CTRL_FLUSH];
    assign fifo_pop   = avl.avl_read && (avl.avl_address == REG_EVENT) && !empty;

    touch_evt_fifo #(.AW(FIFO_AW), .W(32)) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (evt_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .wdata (evt_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow   <= 1'b0;
            irq_en     <= 1'b0;
            move_thr   <= MOVE_THR_RST;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            // A dropped event sets overflow even if software clears it in the same cycle.
            if (evt_push && full && !fifo_pop && !fifo_flush)
                overflow <= 1'b1;
            else if (wr_ctrl && avl.avl_writedata[CTRL_OVF_CLR])
                overflow <= 1'b0;
            if (wr_ctrl) irq_en   <= avl.avl_writedata[CTRL_IRQ_EN];
            if (wr_thr)  move_thr <= avl.avl_writedata[7:0];
            if (avl.avl_read) begin
                case (avl.avl_address)
                    REG_STATUS: readdata_q <= {16'd0, 8'(count), 5'd0, overflow, full, empty};
                    REG_EVENT:  readdata_q <= empty ? '0 : head;
                    REG_CTRL:   readdata_q <= {30'd0, overflow, irq_en};
                    default:    readdata_q <= {24'd0, move_thr};
                endcase
            end
            irq_q <= irq_en && !empty;
        end
    end

    assign avl.avl_readdata = readdata_q;
    assign avl.irq          = irq_q;
endmodule

// File: tb/tb_touch_event_queue.sv
module tb_touch_event_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 100;

    logic        sys_clk     = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        touch_done  = 1'b0;
    logic        touch_valid = 1'b0;
    logic [31:0] tp_xy       = '0;

    int n_vec = 0;
    int n_err = 0;

    touch_event_queue_if avl_if ();

    always #5 sys_clk = ~sys_clk;

    touch_event_queue #(
        .FIFO_AW      (2),
        .RELEASE_TO   (24'd100),
        .MOVE_THR_RST (8'd4)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .touch_done  (touch_done),
        .touch_valid (touch_valid),
        .tp_xy       (tp_xy),
        .avl         (avl_if)
    );

    // Expected event word built directly from the word layout.
    function automatic logic [31:0] ev(input logic [1:0] t, input int x, input int y);
        logic [11:0] xx, yy;
        xx = 12'(x);
        yy = 12'(y);
        return {t, 2'b00, xx, 4'h0, yy};
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic avl_rd(input logic [1:0] a, output logic [31:0] d);
        avl_if.avl_address = a;
        avl_if.avl_read    = 1'b1;
        step();
        d = avl_if.avl_readdata;
        avl_if.avl_read = 1'b0;
    endtask

    task automatic avl_wr(input logic [1:0] a, input logic [31:0] d);
        avl_if.avl_address   = a;
        avl_if.avl_writedata = d;
        avl_if.avl_write     = 1'b1;
        step();
        avl_if.avl_write = 1'b0;
    endtask

    task automatic sample(input int x, input int y, input logic v);
        logic [11:0] xx, yy;
        xx = 12'(x);
        yy = 12'(y);
        touch_done  = 1'b1;
        touch_valid = v;
        tp_xy       = {4'h0, xx, 4'h0, yy};
        step();
        touch_done = 1'b0;
    endtask

    task automatic lift();
        touch_valid = 1'b0;
        step();
    endtask

    task automatic drain(input string name, input logic [31:0] exp[$]);
        logic [31:0] d;
        foreach (exp[i]) begin
            avl_rd(2'd1, d);
            n_vec++;
            if (d !== exp[i]) begin
                n_err++;
                $display("FAIL %s[%0d]: got %h expected %h", name, i, d, exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_vec++;
        if (avl_if.avl_readdata !== 32'd0 || avl_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got rd=%h irq=%b expected 0/0", avl_if.avl_readdata, avl_if.irq);
        end
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0001) begin n_err++; $display("FAIL reset_status: got %h expected 00000001", d); end
        avl_rd(2'd3, d);
        n_vec++;
        if (d !== 32'h0000_0004) begin n_err++; $display("FAIL reset_thr: got %h expected 00000004", d); end
        avl_rd(2'd2, d);
        n_vec++;
        if (d !== 32'h0000_0000) begin n_err++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
    endtask

    task automatic test_press_release();
        logic [31:0] d;
        sample(100, 200, 1'b1);
        sample(100, 200, 1'b1);
        lift();
        drain("press_release", '{ev(2'b01, 100, 200), ev(2'b11, 100, 200)});
        step();
        n_vec++;
        if (avl_if.avl_readdata !== ev(2'b11, 100, 200)) begin
            n_err++;
            $display("FAIL readdata_hold: got %h expected %h", avl_if.avl_readdata, ev(2'b11, 100, 200));
        end
        avl_rd(2'd1, d);
        n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL empty_event_read: got %h expected 00000000", d); end
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0001) begin n_err++; $display("FAIL pr_status: got %h expected 00000001", d); end
    endtask

    task automatic test_move();
        logic [31:0] d;
        sample(100, 200, 1'b1);
        sample(102, 201, 1'b1);
        sample(105, 200, 1'b1);
        lift();
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0300) begin n_err++; $display("FAIL move_status: got %h expected 00000300", d); end
        drain("move", '{ev(2'b01, 100, 200), ev(2'b10, 105, 200), ev(2'b11, 105, 200)});
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        sample(10, 20, 1'b1);
        repeat (TO - 1) step();
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0100) begin n_err++; $display("FAIL timeout_early: got %h expected 00000100", d); end
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0200) begin n_err++; $display("FAIL timeout_fire: got %h expected 00000200", d); end
        sample(30, 40, 1'b1);
        lift();
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0402) begin n_err++; $display("FAIL timeout_full: got %h expected 00000402", d); end
        drain("timeout", '{ev(2'b01, 10, 20), ev(2'b11, 10, 20), ev(2'b01, 30, 40), ev(2'b11, 30, 40)});
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            sample(2 * i + 1, 2 * i + 2, 1'b1);
            lift();
        end
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0406) begin n_err++; $display("FAIL ovf_status: got %h expected 00000406", d); end
        avl_rd(2'd2, d);
        n_vec++;
        if (d !== 32'h0000_0002) begin n_err++; $display("FAIL ovf_ctrl: got %h expected 00000002", d); end
        avl_wr(2'd2, 32'h2);
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0402) begin n_err++; $display("FAIL ovf_cleared: got %h expected 00000402", d); end
        drain("overflow", '{ev(2'b01, 1, 2), ev(2'b11, 1, 2), ev(2'b01, 3, 4), ev(2'b11, 3, 4)});
    endtask

    task automatic test_irq();
        logic [31:0] d;
        avl_wr(2'd2, 32'h1);
        n_vec++;
        if (avl_if.irq !== 1'b0) begin n_err++; $display("FAIL irq_idle: got %b expected 0", avl_if.irq); end
        sample(50, 60, 1'b1);
        step();
        n_vec++;
        if (avl_if.irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", avl_if.irq); end
        avl_rd(2'd1, d);
        step();
        n_vec++;
        if (avl_if.irq !== 1'b0) begin n_err++; $display("FAIL irq_drop: got %b expected 0", avl_if.irq); end
        lift();
        sample(70, 80, 1'b1);
        lift();
        sample(90, 100, 1'b1);
        // full FIFO: RELEASE push and EVENT pop land on the same edge
        touch_valid = 1'b0;
        avl_rd(2'd1, d);
        n_vec++;
        if (d !== ev(2'b11, 50, 60)) begin n_err++; $display("FAIL pushpop_head: got %h expected %h", d, ev(2'b11, 50, 60)); end
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0402) begin n_err++; $display("FAIL pushpop_status: got %h expected 00000402", d); end
        drain("pushpop", '{ev(2'b01, 70, 80), ev(2'b11, 70, 80), ev(2'b01, 90, 100), ev(2'b11, 90, 100)});
        step();
        n_vec++;
        if (avl_if.irq !== 1'b0) begin n_err++; $display("FAIL irq_empty: got %b expected 0", avl_if.irq); end
        avl_wr(2'd2, 32'h0);
    endtask

    task automatic test_flush();
        logic [31:0] d;
        sample(7, 7, 1'b1);
        // flush in the same cycle as the RELEASE push: both must vanish
        touch_valid          = 1'b0;
        avl_if.avl_address   = 2'd2;
        avl_if.avl_writedata = 32'h4;
        avl_if.avl_write     = 1'b1;
        step();
        avl_if.avl_write = 1'b0;
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0001) begin n_err++; $display("FAIL flush_status: got %h expected 00000001", d); end
        sample(8, 8, 1'b1);
        lift();
        drain("after_flush", '{ev(2'b01, 8, 8), ev(2'b11, 8, 8)});
    endtask

    // Reference model state for the random test.
    logic        m_pressed;
    int          m_lx, m_ly, m_idle, m_thr;
    logic        m_ovf;
    logic [31:0] m_q[$];

    task automatic rcycle(input logic done, input logic valid, input int x, input int y,
                          input logic rd, input logic [1:0] a,
                          output logic [31:0] exp_rd, output logic [31:0] got);
        logic [31:0] evw;
        logic        has_ev;
        int          dx, dy, sz;
        logic [11:0] xx, yy;
        logic [3:0]  gx, gy;
        sz = m_q.size();
        exp_rd = '0;
        if (rd) begin
            case (a)
                2'd0: exp_rd = {16'd0, 8'(sz), 5'd0, m_ovf, sz == DEPTH, sz == 0};
                2'd1: exp_rd = (sz > 0) ? m_q[0] : 32'd0;
                2'd2: exp_rd = {30'd0, m_ovf, 1'b0};
                default: exp_rd = 32'(m_thr);
            endcase
        end
        has_ev = 1'b0;
        evw    = '0;
        if (!m_pressed) begin
            if (done && valid) begin
                has_ev = 1'b1; evw = ev(2'b01, x, y);
                m_lx = x; m_ly = y; m_idle = 0; m_pressed = 1'b1;
            end
        end else if (!valid) begin
            has_ev = 1'b1; evw = ev(2'b11, m_lx, m_ly); m_pressed = 1'b0;
        end else if (done) begin
            dx = (x > m_lx) ? x - m_lx : m_lx - x;
            dy = (y > m_ly) ? y - m_ly : m_ly - y;
            if (dx >= m_thr || dy >= m_thr) begin
                has_ev = 1'b1; evw = ev(2'b10, x, y);
                m_lx = x; m_ly = y;
            end
            m_idle = 0;
        end else if (m_idle == int'(TO) - 1) begin
            has_ev = 1'b1; evw = ev(2'b11, m_lx, m_ly); m_pressed = 1'b0; m_idle = 0;
        end else begin
            m_idle++;
        end
        if (rd && a == 2'd1 && m_q.size() > 0) void'(m_q.pop_front());
        if (has_ev) begin
            if (m_q.size() < DEPTH) m_q.push_back(evw);
            else m_ovf = 1'b1;
        end
        xx = 12'(x); yy = 12'(y);
        gx = 4'($urandom_range(0, 15)); gy = 4'($urandom_range(0, 15));
        touch_done         = done;
        touch_valid        = valid;
        tp_xy              = {gx, xx, gy, yy};
        avl_if.avl_address = a;
        avl_if.avl_read    = rd;
        step();
        got = avl_if.avl_readdata;
        touch_done      = 1'b0;
        avl_if.avl_read = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic        done, valid, rd;
        logic [1:0]  a;
        int          rx, ry;
        m_pressed = 1'b0; m_lx = 0; m_ly = 0; m_idle = 0; m_ovf = 1'b0;
        m_q.delete();
        m_thr = int'($urandom_range(0, 7));
        avl_wr(2'd3, 32'(m_thr));
        avl_rd(2'd3, d);
        n_vec++;
        if (d !== 32'(m_thr)) begin n_err++; $display("FAIL rand_thr: got %h expected %h", d, 32'(m_thr)); end
        rx = 2000; ry = 2000;
        for (int i = 0; i < 400; i++) begin
            rx += int'($urandom_range(0, 12)) - 6;
            ry += int'($urandom_range(0, 12)) - 6;
            if ($urandom_range(0, 30) == 0) begin
                rx = int'($urandom_range(0, 4095));
                ry = int'($urandom_range(0, 4095));
            end
            if (rx < 0) rx = 0;
            if (rx > 4095) rx = 4095;
            if (ry < 0) ry = 0;
            if (ry > 4095) ry = 4095;
            done  = ($urandom_range(0, 2) == 0);
            valid = m_pressed ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 1) == 0);
            if (i == 149) begin done = 1'b1; valid = 1'b1; end
            if (i >= 150 && i < 280) begin done = 1'b0; valid = 1'b1; end
            rd = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'd1;
            rcycle(done, valid, rx, ry, rd, a, e, d);
            if (rd) begin
                n_vec++;
                if (d !== e) begin
                    n_err++;
                    $display("FAIL rand_read[%0d] addr %0d: got %h expected %h", i, a, d, e);
                end
            end
        end
        rcycle(1'b0, 1'b0, rx, ry, 1'b1, 2'd0, e, d);
        n_vec++;
        if (d !== e) begin n_err++; $display("FAIL rand_status: got %h expected %h", d, e); end
        avl_wr(2'd2, 32'h6);
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0001) begin n_err++; $display("FAIL rand_flush: got %h expected 00000001", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        avl_wr(2'd2, 32'h1);
        avl_wr(2'd3, 32'd9);
        sample(100, 200, 1'b1);
        sample(110, 200, 1'b1);
        sample(120, 200, 1'b1);
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0300 || avl_if.irq !== 1'b1) begin
            n_err++;
            $display("FAIL prereset: got status=%h irq=%b expected 00000300/1", d, avl_if.irq);
        end
        #2;
        sys_rst_n   = 1'b0;
        touch_valid = 1'b0;
        #1;
        n_vec++;
        if (avl_if.avl_readdata !== 32'd0 || avl_if.irq !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got rd=%h irq=%b expected 0/0", avl_if.avl_readdata, avl_if.irq);
        end
        step();
        step();
        sys_rst_n = 1'b1;
        avl_rd(2'd0, d);
        n_vec++;
        if (d !== 32'h0000_0001) begin n_err++; $display("FAIL postreset_status: got %h expected 00000001", d); end
        avl_rd(2'd3, d);
        n_vec++;
        if (d !== 32'h0000_0004) begin n_err++; $display("FAIL postreset_thr: got %h expected 00000004", d); end
        avl_rd(2'd2, d);
        n_vec++;
        if (d !== 32'h0000_0000) begin n_err++; $display("FAIL postreset_ctrl: got %h expected 00000000", d); end
    endtask

    initial begin
        avl_if.avl_address   = '0;
        avl_if.avl_write     = 1'b0;
        avl_if.avl_writedata = '0;
        avl_if.avl_read      = 1'b0;
        #1;
        repeat (3) step();
        sys_rst_n = 1'b1;
        test_reset();
        test_press_release();
        test_move();
        test_timeout();
        test_overflow();
        test_irq();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within 2 ms");
        $fatal(1);
    end
endmodule
